// File: rtl/cpu_alu_pkg.sv
// Shared ALU constants: Signal operation codes, multiplier FSM states, iteration count.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_alu_pkg;

  localparam logic [5:0] MULTU_CODE = 6'b011001;
  localparam logic [5:0] MULT_CODE  = 6'b011000;
  localparam logic [5:0] DIVU_CODE  = 6'b011011;
  localparam logic [5:0] OUT_CODE   = 6'b111111;

  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_abs_negate.sv
// Conditional two's-complement negate: magnitude of a signed operand, or sign fix-up of a product.
// Latency: combinational.
// Backpressure: none.
// Ports: value (W) in, negate (1) in, result (W) out = negate ? -value : value.
// Only built with MULT_SIGNED_EN defined.
`ifdef MULT_SIGNED_EN
module shift_add_multiplier_abs_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule
`endif

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH unsigned shift-add multiplier driven by ALU Signal codes.
// Latency: one iteration per MULTU cycle, WIDTH MULTU cycles (load included) to DONE; OUT publishes on the same edge.
// Backpressure: none; any unrecognised Signal pauses the unit with all state held.
// Ports: clk, reset (sync, active-high), dataA/dataB operands (sampled on load only),
//        Signal op code, dataOut registered {HI,LO}, busy (state RUN), done (state DONE).
// Optional: MULT_SIGNED_EN adds signed MULT loads (magnitude multiply, sign applied on OUT).
module shift_add_multiplier
  import cpu_alu_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] MULTU_CODE = cpu_alu_pkg::MULTU_CODE,
  parameter logic [5:0] OUT_CODE   = cpu_alu_pkg::OUT_CODE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  input  logic [5:0]           Signal,
  output logic [2*WIDTH-1:0]   dataOut,
  output logic                 busy,
  output logic                 done
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t       state_q, state_d;
  logic [PW-1:0]    product_q, product_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    data_out_q, data_out_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             is_out;
  logic             is_mult;
  logic             is_step;
  logic [WIDTH-1:0] op_a, op_b;
  logic [PW-1:0]    result;

  assign is_out = (Signal == OUT_CODE);

`ifdef MULT_SIGNED_EN
  logic             sign_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    signed_product;

  assign is_mult = (Signal == MULT_CODE);

  shift_add_multiplier_abs_negate #(.W(WIDTH)) u_abs_a (
    .value  (dataA),
    .negate (dataA[WIDTH-1]),
    .result (a_mag)
  );

  shift_add_multiplier_abs_negate #(.W(WIDTH)) u_abs_b (
    .value  (dataB),
    .negate (dataB[WIDTH-1]),
    .result (b_mag)
  );

  shift_add_multiplier_abs_negate #(.W(PW)) u_neg_p (
    .value  (product_q),
    .negate (sign_q),
    .result (signed_product)
  );

  assign op_a   = is_mult ? a_mag : dataA;
  assign op_b   = is_mult ? b_mag : dataB;
  assign result = signed_product;

  // Sign is captured on the load cycle only; a MULTU load stores 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
    end else if (is_out) begin
      sign_q <= 1'b0;
    end else if (state_q == IDLE && (is_mult || Signal == MULTU_CODE)) begin
      sign_q <= is_mult & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
    end
  end
`else
  assign is_mult = 1'b0;
  assign op_a    = dataA;
  assign op_b    = dataB;
  assign result  = product_q;
`endif

  // MULT steps a running operation just like MULTU (only meaningful when enabled).
  assign is_step = (Signal == MULTU_CODE) || is_mult;

  always_comb begin
    state_d    = state_q;
    product_d  = product_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (is_out) begin
      // Publish whatever has accumulated (partial on abort) and rearm.
      data_out_d = result;
      state_d    = IDLE;
      product_d  = '0;
      mcand_d    = '0;
      mplier_d   = '0;
      count_d    = '0;
    end else if (is_step) begin
      case (state_q)
        IDLE: begin
          // Load cycle doubles as iteration 0 using multiplier bit 0.
          product_d = op_b[0] ? {{WIDTH{1'b0}}, op_a} : '0;
          mcand_d   = {{WIDTH{1'b0}}, op_a} << 1;
          mplier_d  = op_b >> 1;
          count_d   = CNT_W'(1);
          state_d   = RUN;
        end
        RUN: begin
          if (mplier_q[0]) begin
            product_d = product_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
          if (count_d == CNT_W'(WIDTH)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          // Extra steps are ignored; product and count stay put.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      product_q  <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      product_q  <= product_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  assign dataOut = data_out_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule
